// File: rtl/vreg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vreg_arb_pkg
//  Purpose  : Shared types and default sizing for the vector-register bank
//             arbiter and its round-robin grant logic.
//  Revision : 1.0  initial release
// ============================================================================
package vreg_arb_pkg;

  // Default bank geometry
  localparam int DEF_WORD_SIZE = 512;
  localparam int DEF_NUM_REGS  = 8;
  localparam int DEF_NUM_REQ   = 4;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage : vreg_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. The search begins at ptr and
//             walks upward with wrap-around; the first asserted request wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  assign any = |req;

  // Walk offsets from farthest to nearest so the request closest to ptr wins
  always_comb begin
    int            cand;
    logic [IW-1:0] sel;
    cand       = 0;
    sel        = '0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      sel = IW'(cand);
      if (req[sel]) gnt_idx = sel;
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/vreg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vreg_bank_arbiter
//  Purpose  : Round-robin arbiter and access sequencer for a bank of vector
//             registers on a shared data-in / tri-state data-out bus.
//             IDLE grants, ACCESS drives the bank, DONE acknowledges.
//  Revision : 1.0  initial release
// ============================================================================
module vreg_bank_arbiter
  import vreg_arb_pkg::*;
#(
  parameter  int WordSize = DEF_WORD_SIZE,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_REQ  = DEF_NUM_REQ,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*AW-1:0]       req_addr,
  input  logic [NUM_REQ*WordSize-1:0] req_wdata,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic                        rsp_valid,
  output logic [WordSize-1:0]         rsp_data,
  output logic [IW-1:0]               rsp_id,
  output logic                        rsp_err,
  output logic [NUM_REGS-1:0]         bank_cs,
  output logic                        bank_we,
  output logic                        bank_oe,
  output logic [WordSize-1:0]         bank_din,
  input  logic [WordSize-1:0]         bank_dout,
  output logic                        busy
);

  // One-hot register select; all-zero for an address past the last register
  function automatic logic [NUM_REGS-1:0] decode_addr(input logic [AW-1:0] a);
    decode_addr = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (a == AW'(r)) decode_addr[r] = 1'b1;
    end
  endfunction

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [WordSize-1:0]   wdata_q, wdata_d;

  logic [NUM_REGS-1:0]   bank_cs_q, bank_cs_d;
  logic                  bank_we_q, bank_we_d;
  logic                  bank_oe_q, bank_oe_d;
  logic [WordSize-1:0]   bank_din_q, bank_din_d;
  logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [IW-1:0]         rsp_id_q, rsp_id_d;
  logic [WordSize-1:0]   rsp_data_q, rsp_data_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    gnt_onehot;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;

  logic                  sel_we;
  logic [AW-1:0]         sel_addr;
  logic [WordSize-1:0]   sel_wdata;
  logic                  addr_ok;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Route the winning requester's fields to the grant latch
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt_onehot[r]) begin
        sel_we    = req_we[r];
        sel_addr  = req_addr[r*AW +: AW];
        sel_wdata = req_wdata[r*WordSize +: WordSize];
      end
    end
  end

  assign addr_ok = |decode_addr(addr_q);

  // Next-state and registered-output logic; pulses and bank controls default low
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bank_cs_d   = '0;
    bank_we_d   = 1'b0;
    bank_oe_d   = 1'b0;
    bank_din_d  = '0;
    req_ack_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_id_d    = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d    = ACCESS;
          busy_d     = 1'b1;
          idx_d      = gnt_idx;
          we_d       = sel_we;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          bank_cs_d  = decode_addr(sel_addr);
          bank_we_d  = sel_we;
          bank_oe_d  = !sel_we;
          bank_din_d = sel_we ? sel_wdata : '0;
        end
      end
      ACCESS: begin
        state_d          = DONE;
        busy_d           = 1'b1;
        req_ack_d[idx_q] = 1'b1;
        rsp_id_d         = idx_q;
        rsp_valid_d      = !we_q && addr_ok;
        rsp_err_d        = !addr_ok;
        if (!addr_ok)   rsp_data_d = '0;
        else if (!we_q) rsp_data_d = bank_dout;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant latch and output registers; reset abandons any access in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bank_cs_q   <= '0;
      bank_we_q   <= 1'b0;
      bank_oe_q   <= 1'b0;
      bank_din_q  <= '0;
      req_ack_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bank_cs_q   <= bank_cs_d;
      bank_we_q   <= bank_we_d;
      bank_oe_q   <= bank_oe_d;
      bank_din_q  <= bank_din_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bank_cs   = bank_cs_q;
  assign bank_we   = bank_we_q;
  assign bank_oe   = bank_oe_q;
  assign bank_din  = bank_din_q;
  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule : vreg_bank_arbiter
`default_nettype wire

// File: tb/tb_vreg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vreg_bank_arbiter
//  Purpose  : Directed self-checking bench for vreg_bank_arbiter with a
//             register-model bank on a shared tri-state read bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vreg_bank_arbiter;

  // Six registers keep the 3-bit address width while leaving addresses 6 and 7
  // out of range, so the error path is reachable.
  localparam int W  = 512;
  localparam int NR = 6;
  localparam int NQ = 4;
  localparam int AW = 3;
  localparam int IW = 2;

  logic              CLK;
  logic              RST;
  logic [NQ-1:0]     req_valid;
  logic [NQ-1:0]     req_we;
  logic [NQ*AW-1:0]  req_addr;
  logic [NQ*W-1:0]   req_wdata;
  logic [NQ-1:0]     req_ack;
  logic              rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              rsp_err;
  logic [NR-1:0]     bank_cs;
  logic              bank_we;
  logic              bank_oe;
  logic [W-1:0]      bank_din;
  wire  [W-1:0]      bank_dout;
  logic              busy;
  logic              mdl_clr;

  int checks = 0;
  int errors = 0;

  vreg_bank_arbiter #(.WordSize(W), .NUM_REGS(NR), .NUM_REQ(NQ)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .bank_cs   (bank_cs),
    .bank_we   (bank_we),
    .bank_oe   (bank_oe),
    .bank_din  (bank_din),
    .bank_dout (bank_dout),
    .busy      (busy)
  );

  // Register models: write on cs&we at the clock edge, drive the bus on cs&oe
  for (genvar g = 0; g < NR; g++) begin : g_reg
    logic [W-1:0] val;
    always @(posedge CLK) begin
      if (mdl_clr)                    val <= {64{8'(8'h10 + g)}};
      else if (bank_cs[g] && bank_we) val <= bank_din;
    end
    assign bank_dout = (bank_cs[g] && bank_oe) ? val : {W{1'bz}};
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_we[r]              = we;
    req_addr[r*AW +: AW]   = a;
    req_wdata[r*W +: W]    = d;
    req_valid[r]           = 1'b1;
  endtask

  logic [W-1:0] pat_a5, pat_dead, pat_alt, pat_t5;
  logic [W-1:0] exp_rd [NQ];
  int           n;
  int           exp_r;

  initial begin
    pat_a5   = {64{8'hA5}};
    pat_dead = {16{32'hDEADBEEF}};
    pat_alt  = {16{32'h0BADF00D}};
    pat_t5   = {16{32'h12345678}};
    RST       = 1'b0;
    mdl_clr   = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // 1. Reset state
    tick();
    tick();
    check("rst_bank_cs",  W'(bank_cs), '0);
    check("rst_bank_we",  W'(bank_we), '0);
    check("rst_bank_oe",  W'(bank_oe), '0);
    check("rst_bank_din", bank_din, '0);
    check("rst_req_ack",  W'(req_ack), '0);
    check("rst_rsp_valid", W'(rsp_valid), '0);
    check("rst_rsp_err",  W'(rsp_err), '0);
    check("rst_rsp_id",   W'(rsp_id), '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_busy",     W'(busy), '0);
    RST     = 1'b1;
    mdl_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_busy", W'(busy), '0);
    end

    // 2. Requester 0 writes reg 3, then reads it back
    set_req(0, 1'b1, 3'd3, pat_a5);
    tick();
    check("wr_busy",   W'(busy), 1);
    check("wr_cs",     W'(bank_cs), W'(6'b001000));
    check("wr_we",     W'(bank_we), 1);
    check("wr_oe",     W'(bank_oe), 0);
    check("wr_din",    bank_din, pat_a5);
    tick();
    req_valid = '0;
    check("wr_ack",    W'(req_ack), W'(4'b0001));
    check("wr_rvalid", W'(rsp_valid), 0);
    check("wr_cs_off", W'(bank_cs), 0);
    check("wr_reg3",   g_reg[3].val, pat_a5);
    tick();
    check("wr_idle",   W'(busy), 0);
    check("wr_ack_pulse", W'(req_ack), 0);
    set_req(0, 1'b0, 3'd3, '0);
    tick();
    check("rd_cs",     W'(bank_cs), W'(6'b001000));
    check("rd_oe",     W'(bank_oe), 1);
    check("rd_we",     W'(bank_we), 0);
    check("rd_din",    bank_din, '0);
    tick();
    req_valid = '0;
    check("rd_ack",    W'(req_ack), W'(4'b0001));
    check("rd_rvalid", W'(rsp_valid), 1);
    check("rd_data",   rsp_data, pat_a5);
    check("rd_id",     W'(rsp_id), 0);
    tick();
    tick();
    check("rd_data_hold", rsp_data, pat_a5);

    // 6. Requester 1 changes its fields right after the grant
    set_req(1, 1'b1, 3'd1, pat_dead);
    tick();
    set_req(1, 1'b1, 3'd5, pat_alt);
    check("lat_cs",    W'(bank_cs), W'(6'b000010));
    check("lat_din",   bank_din, pat_dead);
    tick();
    req_valid = '0;
    check("lat_ack",   W'(req_ack), W'(4'b0010));
    check("lat_id",    W'(rsp_id), 1);
    check("lat_reg1",  g_reg[1].val, pat_dead);
    check("lat_reg5",  g_reg[5].val, {64{8'h15}});
    tick();

    // 4. Requester 2 reads an out-of-range address
    set_req(2, 1'b0, 3'd7, '0);
    tick();
    check("err_cs",    W'(bank_cs), 0);
    tick();
    req_valid = '0;
    check("err_ack",   W'(req_ack), W'(4'b0100));
    check("err_flag",  W'(rsp_err), 1);
    check("err_rvalid", W'(rsp_valid), 0);
    check("err_data",  rsp_data, '0);
    check("err_id",    W'(rsp_id), 2);
    check("err_reg0",  g_reg[0].val, {64{8'h10}});
    check("err_reg4",  g_reg[4].val, {64{8'h14}});
    tick();
    check("err_pulse", W'(rsp_err), 0);

    // 5. Reset lands in the middle of a write access
    set_req(3, 1'b1, 3'd4, pat_t5);
    tick();
    check("ar_cs",     W'(bank_cs), W'(6'b010000));
    check("ar_we",     W'(bank_we), 1);
    #2;
    RST = 1'b0;
    #1;
    check("ar_cs_async",   W'(bank_cs), 0);
    check("ar_we_async",   W'(bank_we), 0);
    check("ar_din_async",  bank_din, '0);
    check("ar_busy_async", W'(busy), 0);
    tick();
    check("ar_no_ack", W'(req_ack), 0);
    check("ar_reg4",   g_reg[4].val, {64{8'h14}});
    req_valid = '0;
    RST = 1'b1;
    tick();
    check("ar_idle",   W'(busy), 0);
    check("ar_no_ack2", W'(req_ack), 0);

    // 3. All requesters reading continuously; pointer restarted at 0
    exp_rd[0] = {64{8'h10}};
    exp_rd[1] = pat_dead;
    exp_rd[2] = {64{8'h12}};
    exp_rd[3] = pat_a5;
    for (int r = 0; r < NQ; r++) set_req(r, 1'b0, AW'(r), '0);
    for (int k = 0; k < 6; k++) begin
      exp_r = k % NQ;
      n = 0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        check("rr_no_collide", W'(bank_we && bank_oe), 0);
        if (req_ack != '0) begin
          n = c;
          break;
        end
      end
      check("rr_latency", W'(n), W'((k == 0) ? 2 : 3));
      check("rr_ack",     W'(req_ack), W'(4'b0001 << exp_r));
      check("rr_id",      W'(rsp_id), W'(exp_r));
      check("rr_data",    rsp_data, exp_rd[exp_r]);
      check("rr_rvalid",  W'(rsp_valid), 1);
    end
    req_valid = '0;
    tick();
    tick();
    check("end_idle", W'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vreg_bank_arbiter
`default_nettype wire
